// File: rtl/gin_id_scan_ctrl.sv
// gin_id_scan_ctrl
//   Configuration sequencer for the GIN multicast ID scan chain of one bus row.
//   The block collects CHAIN_LEN IDs from a host valid/ready stream and shifts
//   them into the chain. It then pulses done for one cycle.
//   Words enter the buffer in arrival order. Buffer entry 0, the first word
//   accepted, is shifted into the chain first, so after CHAIN_LEN shifts it
//   sits in the last chain stage.
//
//   Optional feature, macro GIN_SCAN_VERIFY_EN: after LOAD, a VERIFY pass
//   shifts the same words a second time. While it shifts, it compares
//   id_scan_out against the buffer. Re-shifting the same words leaves the
//   chain holding what it held after LOAD. Any mismatch sets the sticky err
//   flag. Without the macro, err is tied low.
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   cfg_valid   host ID word valid
//   cfg_ready   block can accept an ID word (IDLE only)
//   cfg_id      ID word
//   set_id      scan-chain shift enable
//   id_scan_in  scan data into chain stage 0 (zero when set_id is low)
//   id_scan_out scan data out of the last chain stage
//   busy        high during LOAD / VERIFY
//   done        one-cycle completion pulse
//   err         sticky readback mismatch, cleared by the first accept of a sequence
module gin_id_scan_ctrl #(
   parameter int unsigned CHAIN_LEN = 14,
   parameter int unsigned ID_LEN    = 5,
   parameter int unsigned CNT_W     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ID_LEN-1:0] cfg_id,
   output logic              set_id,
   output logic [ID_LEN-1:0] id_scan_in,
   input  logic [ID_LEN-1:0] id_scan_out,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned IDX_W = $clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_VERIFY,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  wr_cnt, sh_cnt;
   logic [ID_LEN-1:0] id_buf [CHAIN_LEN];
   logic              accept;
   logic              shifting;
   logic [ID_LEN-1:0] sh_word;

   assign accept   = cfg_valid && cfg_ready;
   assign shifting = (state == S_LOAD) || (state == S_VERIFY);
   assign sh_word  = id_buf[sh_cnt[IDX_W-1:0]];

   // The outputs decode only the registered state and counters.
   // There is no path from cfg_valid to any of them.
   always_comb begin
      state_nx   = state;
      cfg_ready  = 1'b0;
      set_id     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      id_scan_in = '0;
      unique case (state)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid && (wr_cnt == LAST)) state_nx = S_LOAD;
         end
         S_LOAD: begin
            busy       = 1'b1;
            set_id     = 1'b1;
            id_scan_in = sh_word;
            if (sh_cnt == LAST) begin
`ifdef GIN_SCAN_VERIFY_EN
               state_nx = S_VERIFY;
`else
               state_nx = S_DONE;
`endif
            end
         end
         S_VERIFY: begin
`ifdef GIN_SCAN_VERIFY_EN
            busy       = 1'b1;
            set_id     = 1'b1;
            id_scan_in = sh_word;
            if (sh_cnt == LAST) state_nx = S_DONE;
`else
            state_nx = S_IDLE;
`endif
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         wr_cnt <= '0;
         sh_cnt <= '0;
      end else begin
         state <= state_nx;
         if (accept) wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
         // sh_cnt is already zero when entering LOAD, because every pass ends by wrapping it.
         if (shifting) sh_cnt <= (sh_cnt == LAST) ? '0 : sh_cnt + 1'b1;
      end
   end

   // The buffer needs no reset. Every entry is written before LOAD reads it.
   always_ff @(posedge clk) begin
      if (accept) id_buf[wr_cnt[IDX_W-1:0]] <= cfg_id;
   end

`ifdef GIN_SCAN_VERIFY_EN
   // Before each VERIFY shift edge, the last stage holds the word
   // shifted in at the same index during LOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept && (wr_cnt == '0)) begin
         err <= 1'b0;
      end else if ((state == S_VERIFY) && (id_scan_out != sh_word)) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_scan_out;
   assign unused_scan_out = ^id_scan_out;
   assign err = 1'b0;
`endif

endmodule
